rgb_gray_serializer: RTL



---
 rtl/rgb_gray_serializer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rgb_gray_serializer.sv
// RGB-to-luma pipeline feeding a byte FIFO and an MSB-first bit serializer
// over a valid/ready link; drops bytes (sticky overflow) when the FIFO is saturated.
`default_nettype none

module rgb_gray_serializer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       pixel_valid,
  output logic       shift_out,
  output logic       shift_valid,
  input  logic       shift_ready,
  output logic       fifo_full,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  // Pipeline stage 1: weighted products.
  logic [14:0] prod_r;
  logic [15:0] prod_g;
  logic [12:0] prod_b;
  logic        v1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_r <= '0;
      prod_g <= '0;
      prod_b <= '0;
      v1     <= 1'b0;
    end else begin
      v1 <= pixel_valid;
      if (pixel_valid) begin
        prod_r <= 15'd77  * {7'd0, red};
        prod_g <= 16'd150 * {8'd0, green};
        prod_b <= 13'd29  * {5'd0, blue};
      end
    end
  end

  // Pipeline stage 2: rounded sum; the maximum of 65408 keeps the result in 8 bits.
  logic [16:0] sum17;
  logic [7:0]  luma2;
  logic        v2;

  assign sum17 = {2'b00, prod_r} + {1'b0, prod_g} + {4'd0, prod_b} + 17'd128;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      luma2 <= '0;
      v2    <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) luma2 <= 8'(sum17 >> 8);
    end
  end

  // Luma FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          fifo_empty, push, pop_req, drop;

  assign fifo_empty = (count == '0);
  assign push       = v2 && (!fifo_full || pop_req);
  assign drop       = v2 && fifo_full && !pop_req;

  always_comb begin
    count_next = count;
    case ({push, pop_req})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push)    wr_ptr <= AW'(wr_ptr + 1'b1);
      if (pop_req) rd_ptr <= AW'(rd_ptr + 1'b1);
      count     <= count_next;
      fifo_full <= (count_next == CW'(FIFO_DEPTH));
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: storage array has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= luma2;
  end

  // Serializer FSM
  state_t     state, state_next;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop_req    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop_req    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_ready && bit_cnt == 3'd7) begin
          if (!fifo_empty) pop_req    = 1'b1;
          else             state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_valid = (state == SHIFT);
    shift_out   = (state == SHIFT) && shreg[7];
    busy        = v1 || v2 || !fifo_empty || (state == SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (pop_req) begin
      shreg   <= mem[rd_ptr];
      bit_cnt <= '0;
    end else if (state == SHIFT && shift_ready) begin
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

`default_nettype wire
